// File: rtl/r_cpu_test_sequencer.sv
// Run controller and result checker for R_CPU: resets the CPU, clocks it one
// instruction at a time and compares ALU_F/OF/ZF against an expected-result ROM.
module r_cpu_test_sequencer #(
  parameter int DATA_W       = 32,
  parameter int NUM_INSTR    = 64,
  parameter int IDX_W        = 7,
  parameter int RESET_CYCLES = 2,
  parameter int ERR_W        = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              step_mode,
  input  logic              step,
  output logic              cpu_rst,
  output logic              cpu_ce,
  input  logic [DATA_W-1:0] dut_f,
  input  logic              dut_of,
  input  logic              dut_zf,
  output logic [IDX_W-1:0]  exp_addr,
  input  logic [DATA_W-1:0] exp_f,
  input  logic              exp_of,
  input  logic              exp_zf,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [IDX_W-1:0]  first_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_ISSUE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RC_W-1:0]  RST_LAST = RC_W'(RESET_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_INSTR - 1);

  state_t            state_q;
  logic [RC_W-1:0]   rst_cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [IDX_W-1:0]  first_q, first_d;
  logic              step_prev_q;
  logic              cpu_rst_q, cpu_ce_q, busy_q, done_q, pass_q;
  logic              mismatch, step_rise;

  always_comb begin
    mismatch  = (dut_f != exp_f) || (dut_of != exp_of) || (dut_zf != exp_zf);
    step_rise = step & ~step_prev_q;
    err_d     = (mismatch && (err_q != '1)) ? err_q + ERR_W'(1) : err_q;
    first_d   = (mismatch && (first_q == '1)) ? idx_q : first_q;
  end

  // cpu_ce is raised in the ISSUE cycle itself, so the CPU has already
  // executed the instruction by the time CHECK samples its outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rst_cnt_q   <= '0;
      idx_q       <= '0;
      err_q       <= '0;
      first_q     <= '1;
      step_prev_q <= 1'b0;
      cpu_rst_q   <= 1'b1;
      cpu_ce_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      step_prev_q <= step;
      if (abort) begin
        state_q   <= S_IDLE;
        cpu_rst_q <= 1'b1;
        cpu_ce_q  <= 1'b0;
        busy_q    <= 1'b0;
        done_q    <= 1'b0;
        pass_q    <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (start) begin
              state_q   <= S_RST;
              rst_cnt_q <= '0;
              idx_q     <= '0;
              err_q     <= '0;
              first_q   <= '1;
              cpu_rst_q <= 1'b1;
              cpu_ce_q  <= 1'b0;
              busy_q    <= 1'b1;
              done_q    <= 1'b0;
              pass_q    <= 1'b0;
            end
          end
          S_RST: begin
            if (rst_cnt_q == RST_LAST) begin
              state_q   <= S_ISSUE;
              cpu_rst_q <= 1'b0;
              cpu_ce_q  <= ~step_mode;
            end else begin
              rst_cnt_q <= rst_cnt_q + RC_W'(1);
            end
          end
          S_ISSUE: begin
            if (cpu_ce_q) begin
              cpu_ce_q <= 1'b0;
              state_q  <= S_CHECK;
            end else if (!step_mode || step_rise) begin
              cpu_ce_q <= 1'b1;
            end
          end
          S_CHECK: begin
            err_q   <= err_d;
            first_q <= first_d;
            if (idx_q == IDX_LAST) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_d == '0);
            end else begin
              idx_q    <= idx_q + IDX_W'(1);
              state_q  <= S_ISSUE;
              cpu_ce_q <= ~step_mode;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign cpu_rst   = cpu_rst_q;
  assign cpu_ce    = cpu_ce_q;
  assign exp_addr  = idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_cnt   = err_q;
  assign first_err = first_q;

endmodule

// File: tb/tb_r_cpu_test_sequencer.sv
// Randomized bench: models R_CPU as an instruction counter replaying a ROM with
// optional per-instruction corruption, and predicts the sequencer's verdict.
module tb_r_cpu_test_sequencer;
  localparam int N      = 6;
  localparam int RC     = 2;
  localparam int DW     = 32;
  localparam int IW     = 7;
  localparam int EW     = 2;
  localparam int ERRMAX = (1 << EW) - 1;
  localparam int LAT    = 1 + RC + 2 * N;
  localparam int NONE   = (1 << IW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, abort = 1'b0, step_mode = 1'b0, step = 1'b0;
  logic cpu_rst, cpu_ce, busy, done, pass;
  logic [DW-1:0] dut_f, exp_f;
  logic dut_of, dut_zf, exp_of, exp_zf;
  logic [IW-1:0] exp_addr, first_err;
  logic [EW-1:0] err_cnt;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] rom_f [N];
  logic          rom_of [N];
  logic          rom_zf [N];
  logic [DW-1:0] mask_f [N];
  logic          mask_of [N];
  logic          mask_zf [N];

  int cpu_cnt = 0;
  int ce_count = 0;

  always #5 clk = ~clk;

  r_cpu_test_sequencer #(
    .DATA_W(DW), .NUM_INSTR(N), .IDX_W(IW), .RESET_CYCLES(RC), .ERR_W(EW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .step_mode(step_mode), .step(step), .cpu_rst(cpu_rst), .cpu_ce(cpu_ce),
    .dut_f(dut_f), .dut_of(dut_of), .dut_zf(dut_zf), .exp_addr(exp_addr),
    .exp_f(exp_f), .exp_of(exp_of), .exp_zf(exp_zf), .busy(busy), .done(done),
    .pass(pass), .err_cnt(err_cnt), .first_err(first_err)
  );

  // CPU model: executes one instruction per enabled edge, result = ROM ^ fault mask
  always @(posedge clk) begin
    if (cpu_rst === 1'b1) cpu_cnt <= 0;
    else if (cpu_ce === 1'b1) cpu_cnt <= cpu_cnt + 1;
    if (cpu_ce === 1'b1) ce_count <= ce_count + 1;
  end

  always_comb begin
    dut_f = '0; dut_of = 1'b0; dut_zf = 1'b0;
    if (cpu_cnt > 0 && cpu_cnt <= N) begin
      dut_f  = rom_f[cpu_cnt-1] ^ mask_f[cpu_cnt-1];
      dut_of = rom_of[cpu_cnt-1] ^ mask_of[cpu_cnt-1];
      dut_zf = rom_zf[cpu_cnt-1] ^ mask_zf[cpu_cnt-1];
    end
  end

  always_comb begin
    exp_f = '0; exp_of = 1'b0; exp_zf = 1'b0;
    if (int'(exp_addr) < N) begin
      exp_f  = rom_f[exp_addr];
      exp_of = rom_of[exp_addr];
      exp_zf = rom_zf[exp_addr];
    end
  end

  always @(negedge clk) begin
    checks++;
    if (cpu_rst === 1'b1 && cpu_ce === 1'b1) begin
      failures++;
      $display("FAIL rst_ce_overlap t=%0t cpu_rst=%b cpu_ce=%b required not both 1", $time, cpu_rst, cpu_ce);
    end
  end

  function automatic int model_errs();
    int c = 0;
    for (int i = 0; i < N; i++)
      if (mask_f[i] != 0 || mask_of[i] || mask_zf[i]) c++;
    return (c > ERRMAX) ? ERRMAX : c;
  endfunction

  function automatic int model_first();
    for (int i = 0; i < N; i++)
      if (mask_f[i] != 0 || mask_of[i] || mask_zf[i]) return i;
    return NONE;
  endfunction

  task automatic load_run(input int fault_pct);
    for (int i = 0; i < N; i++) begin
      rom_f[i] = $urandom; rom_of[i] = 1'($urandom_range(0, 1)); rom_zf[i] = 1'($urandom_range(0, 1));
      mask_f[i] = '0; mask_of[i] = 1'b0; mask_zf[i] = 1'b0;
      if ($urandom_range(0, 99) < fault_pct) begin
        case ($urandom_range(0, 2))
          0: mask_f[i] = $urandom | 32'h1;
          1: mask_of[i] = 1'b1;
          default: mask_zf[i] = 1'b1;
        endcase
      end
    end
  endtask

  task automatic run_to_done(output int cyc, output int err1, output int first1, output bit to);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 1; err1 = int'(err_cnt); first1 = int'(first_err);
    while (done !== 1'b1 && cyc < 400) begin @(negedge clk); cyc++; end
    to = (done !== 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (cpu_rst !== 1'b1) begin failures++; $display("FAIL reset_cpu_rst got=%b want=1", cpu_rst); end
    checks++; if (cpu_ce !== 1'b0) begin failures++; $display("FAIL reset_cpu_ce got=%b want=0", cpu_ce); end
    checks++; if (exp_addr !== '0) begin failures++; $display("FAIL reset_exp_addr got=%0d want=0", exp_addr); end
    checks++; if (err_cnt !== '0) begin failures++; $display("FAIL reset_err_cnt got=%0d want=0", err_cnt); end
    checks++; if (first_err !== IW'(NONE)) begin failures++; $display("FAIL reset_first_err got=%h want=%h", first_err, NONE); end
    checks++; if ({busy, done, pass} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b%b%b want=000", busy, done, pass); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_free_run_clean();
    int cyc, e1, f1, base; bit to;
    load_run(0);
    base = ce_count;
    run_to_done(cyc, e1, f1, to);
    checks++; if (to || cyc != LAT) begin failures++; $display("FAIL clean_latency got=%0d want=%0d", cyc, LAT); end
    checks++; if (pass !== 1'b1 || err_cnt !== '0) begin failures++; $display("FAIL clean_pass got pass=%b err=%0d want pass=1 err=0", pass, err_cnt); end
    checks++; if (first_err !== IW'(NONE)) begin failures++; $display("FAIL clean_first got=%h want=%h", first_err, NONE); end
    checks++; if (ce_count - base != N) begin failures++; $display("FAIL clean_ce_pulses got=%0d want=%0d", ce_count - base, N); end
    checks++; if ({cpu_rst, cpu_ce, busy} !== 3'b000) begin failures++; $display("FAIL done_outputs got rst=%b ce=%b busy=%b want 000", cpu_rst, cpu_ce, busy); end
  endtask

  task automatic test_fixed_mismatch();
    int cyc, e1, f1; bit to;
    load_run(0);
    mask_f[2] = 32'h0000_0100; mask_f[3] = 32'h8000_0000;
    run_to_done(cyc, e1, f1, to);
    checks++; if (to || err_cnt !== EW'(2) || first_err !== IW'(2) || pass !== 1'b0)
      begin failures++; $display("FAIL idx2_3_mismatch got err=%0d first=%0d pass=%b want err=2 first=2 pass=0", err_cnt, first_err, pass); end
  endtask

  task automatic test_saturate();
    int cyc, e1, f1; bit to;
    load_run(0);
    for (int i = 0; i < 5; i++) mask_zf[i] = 1'b1;
    run_to_done(cyc, e1, f1, to);
    checks++; if (to || err_cnt !== EW'(ERRMAX) || first_err !== IW'(0))
      begin failures++; $display("FAIL saturate got err=%0d first=%0d want err=%0d first=0", err_cnt, first_err, ERRMAX); end
  endtask

  task automatic test_back_to_back();
    int cyc, e1, f1; bit to;
    for (int r = 0; r < 6; r++) begin
      load_run(35);
      run_to_done(cyc, e1, f1, to);
      checks++; if (e1 != 0 || f1 != NONE) begin failures++; $display("FAIL b2b_clear run=%0d got err=%0d first=%0d want 0/%0d", r, e1, f1, NONE); end
      checks++; if (to || cyc != LAT) begin failures++; $display("FAIL b2b_latency run=%0d got=%0d want=%0d", r, cyc, LAT); end
      checks++; if (int'(err_cnt) != model_errs() || int'(first_err) != model_first() || pass !== (model_errs() == 0))
        begin failures++; $display("FAIL b2b_result run=%0d got err=%0d first=%0d pass=%b want err=%0d first=%0d", r, err_cnt, first_err, pass, model_errs(), model_first()); end
    end
  endtask

  task automatic test_step();
    int base, cyc;
    load_run(0);
    step_mode = 1'b1; step = 1'b0;
    base = ce_count;
    @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    step = 1'b1; repeat (10) @(negedge clk);
    checks++; if (ce_count - base != 1) begin failures++; $display("FAIL step_hold got=%0d pulses want=1", ce_count - base); end
    step = 1'b0; repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      step = 1'b1; repeat (2) @(negedge clk);
      step = 1'b0; repeat (3) @(negedge clk);
    end
    checks++; if (exp_addr !== IW'(3) || busy !== 1'b1 || ce_count - base != 3)
      begin failures++; $display("FAIL step_three got idx=%0d busy=%b pulses=%0d want 3/1/3", exp_addr, busy, ce_count - base); end
    step_mode = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
    checks++; if (done !== 1'b1 || pass !== 1'b1 || ce_count - base != N)
      begin failures++; $display("FAIL step_finish got done=%b pass=%b pulses=%0d want 1/1/%0d", done, pass, ce_count - base, N); end
  endtask

  task automatic test_abort();
    int cyc, e1, f1; bit to;
    load_run(0);
    mask_of[0] = 1'b1;
    @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!(busy === 1'b1 && exp_addr === IW'(1) && cpu_ce === 1'b0 && cpu_rst === 1'b0) && cyc < 50) begin
      @(negedge clk); cyc++;
    end
    checks++; if (cyc >= 50) begin failures++; $display("FAIL abort_reach_check got timeout want CHECK idx1"); end
    abort = 1'b1; @(negedge clk);
    checks++; if ({cpu_rst, cpu_ce, busy, done} !== 4'b1000)
      begin failures++; $display("FAIL abort_idle got rst=%b ce=%b busy=%b done=%b want 1000", cpu_rst, cpu_ce, busy, done); end
    checks++; if (err_cnt !== EW'(1) || first_err !== IW'(0))
      begin failures++; $display("FAIL abort_keep got err=%0d first=%0d want 1/0", err_cnt, first_err); end
    abort = 1'b0;
    load_run(0);
    run_to_done(cyc, e1, f1, to);
    checks++; if (e1 != 0 || to || pass !== 1'b1)
      begin failures++; $display("FAIL abort_restart got err1=%0d pass=%b want 0/1", e1, pass); end
  endtask

  task automatic test_start_ignored();
    int cyc; bit inj;
    load_run(40);
    inj = 1'b0;
    @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 400) begin
      start = (!inj && cpu_ce === 1'b1 && exp_addr === IW'(2));
      if (start) inj = 1'b1;
      @(negedge clk); cyc++;
    end
    start = 1'b0;
    checks++; if (!inj || cyc != LAT) begin failures++; $display("FAIL start_ignored_latency got=%0d inj=%b want=%0d", cyc, inj, LAT); end
    checks++; if (int'(err_cnt) != model_errs() || int'(first_err) != model_first())
      begin failures++; $display("FAIL start_ignored_result got err=%0d first=%0d want %0d/%0d", err_cnt, first_err, model_errs(), model_first()); end
  endtask

  task automatic test_reset_midrun();
    load_run(60);
    @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
    repeat ($urandom_range(3, 10)) @(negedge clk);
    reset = 1'b1; @(negedge clk);
    checks++; if ({cpu_rst, cpu_ce, exp_addr, err_cnt, first_err, busy, done, pass} !== {1'b1, 1'b0, IW'(0), EW'(0), IW'(NONE), 3'b000})
      begin failures++; $display("FAIL midrun_reset got rst=%b ce=%b idx=%0d err=%0d first=%h flags=%b%b%b want reset values", cpu_rst, cpu_ce, exp_addr, err_cnt, first_err, busy, done, pass); end
    reset = 1'b0; @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      rom_f[i] = '0; rom_of[i] = 1'b0; rom_zf[i] = 1'b0;
      mask_f[i] = '0; mask_of[i] = 1'b0; mask_zf[i] = 1'b0;
    end
    test_reset();
    test_free_run_clean();
    test_fixed_mismatch();
    test_saturate();
    test_back_to_back();
    test_step();
    test_abort();
    test_start_ignored();
    test_reset_midrun();
    test_free_run_clean();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
